// File: rtl/ariane_pkg.sv
// ============================================================================
// Module      : ariane_pkg
// Description : Shared types and constants for the instruction-alignment front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ariane_pkg;

  localparam int unsigned PARCEL_W = 16;

  typedef enum logic [1:0] {
    ALIGNED  = 2'd0,
    UPPER_C  = 2'd1,
    STRADDLE = 2'd2
  } align_state_e;

  // A 16-bit parcel starts a compressed instruction unless its low bits are 2'b11.
  function automatic logic is_rvc(input logic [PARCEL_W-1:0] parcel);
    return parcel[1:0] != 2'b11;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_align_seq.sv
// ============================================================================
// Module      : instr_align_seq
// Description : Re-aligns word-aligned fetch data into whole RV instructions
//               (16/32-bit). Compressed support enabled by INSTR_ALIGN_SEQ_RVC_EN;
//               otherwise fetch words pass straight through.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_align_seq
  import ariane_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_data_i,
  input  logic [63:0] fetch_addr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [63:0] instr_addr_o,
  output logic        is_compressed_o
);

`ifdef INSTR_ALIGN_SEQ_RVC_EN

  align_state_e          r_state;
  align_state_e          w_state_nxt;
  logic [PARCEL_W-1:0]   r_parcel;
  logic [PARCEL_W-1:0]   w_parcel_nxt;
  logic [63:0]           r_addr;
  logic [63:0]           w_addr_nxt;
  logic [PARCEL_W-1:0]   w_lo;
  logic [PARCEL_W-1:0]   w_hi;
  logic                  w_fire;

  assign w_lo   = fetch_data_i[PARCEL_W-1:0];
  assign w_hi   = fetch_data_i[31:PARCEL_W];
  assign w_fire = fetch_valid_i && instr_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ALIGNED;
      r_parcel <= '0;
      r_addr   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_parcel <= w_parcel_nxt;
      r_addr   <= w_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_parcel_nxt  = r_parcel;
    w_addr_nxt    = r_addr;
    instr_valid_o = 1'b0;
    fetch_ready_o = 1'b0;
    instr_o       = '0;
    instr_addr_o  = r_addr;

    case (r_state)
      ALIGNED: begin
        instr_addr_o = fetch_addr_i;
        if (!fetch_addr_i[1]) begin
          instr_valid_o = fetch_valid_i;
          fetch_ready_o = instr_ready_i;
          if (!is_rvc(w_lo)) begin
            instr_o = fetch_data_i;
          end else begin
            instr_o = {16'h0000, w_lo};
            if (w_fire) begin
              w_parcel_nxt = w_hi;
              w_addr_nxt   = fetch_addr_i + 64'd2;
              w_state_nxt  = is_rvc(w_hi) ? UPPER_C : STRADDLE;
            end
          end
        end else if (is_rvc(w_hi)) begin
          instr_valid_o = fetch_valid_i;
          fetch_ready_o = instr_ready_i;
          instr_o       = {16'h0000, w_hi};
        end else begin
          // Redirect into the first half of a 32-bit instruction: swallow the word.
          fetch_ready_o = 1'b1;
          if (fetch_valid_i) begin
            w_parcel_nxt = w_hi;
            w_addr_nxt   = fetch_addr_i;
            w_state_nxt  = STRADDLE;
          end
        end
      end
      UPPER_C: begin
        instr_valid_o = 1'b1;
        instr_o       = {16'h0000, r_parcel};
        if (instr_ready_i) begin
          w_state_nxt = ALIGNED;
        end
      end
      STRADDLE: begin
        instr_valid_o = fetch_valid_i;
        fetch_ready_o = instr_ready_i;
        instr_o       = {w_lo, r_parcel};
        if (w_fire) begin
          w_parcel_nxt = w_hi;
          w_addr_nxt   = r_addr + 64'd4;
          w_state_nxt  = is_rvc(w_hi) ? UPPER_C : STRADDLE;
        end
      end
      default: begin
        w_state_nxt = ALIGNED;
      end
    endcase

    if (flush_i) begin
      instr_valid_o = 1'b0;
      fetch_ready_o = 1'b1;
      w_state_nxt   = ALIGNED;
    end
  end

  assign is_compressed_o = is_rvc(instr_o[PARCEL_W-1:0]);

`else

  logic w_unused;

  assign instr_valid_o   = fetch_valid_i;
  assign fetch_ready_o   = instr_ready_i;
  assign instr_o         = fetch_data_i;
  assign instr_addr_o    = fetch_addr_i;
  assign is_compressed_o = 1'b0;
  assign w_unused        = ^{clk_i, rst_ni, flush_i};

`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_align_seq.sv
// ============================================================================
// Module      : tb_instr_align_seq
// Description : Randomized self-checking bench for instr_align_seq; the expected
//               instruction stream is parsed from the fetched parcel stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_align_seq;

`ifdef INSTR_ALIGN_SEQ_RVC_EN
  localparam bit RVC_EN = 1'b1;
`else
  localparam bit RVC_EN = 1'b0;
`endif
  localparam int BUDGET = 500;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_data_i;
  logic [63:0] fetch_addr_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [63:0] instr_addr_o;
  logic        is_compressed_o;

  instr_align_seq u_dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .fetch_valid_i   (fetch_valid_i),
    .fetch_ready_o   (fetch_ready_o),
    .fetch_data_i    (fetch_data_i),
    .fetch_addr_i    (fetch_addr_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_o         (instr_o),
    .instr_addr_o    (instr_addr_o),
    .is_compressed_o (is_compressed_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] addr;
    bit          buffered;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] seg_words[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] word_addr(input logic [63:0] base, input int i);
    if (i == 0) return base;
    return {base[63:2], 2'b00} + 64'(i) * 64'd4;
  endfunction

  function automatic logic [15:0] rand_half();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
    else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
    return h;
  endfunction

  // Flatten the words into a parcel stream and split it into instructions.
  // An upper-half compressed instruction whose word was already taken must be
  // presented from the buffer, i.e. with the fetch side stalled.
  function automatic void build_expected(input logic [63:0] base);
    logic [15:0] par[$];
    logic [63:0] pa[$];
    bit          up[$];
    logic [15:0] p;
    logic [63:0] wa;
    bit          entry_hi;
    int          j;
    exp_q.delete();
    for (int i = 0; i < seg_words.size(); i++) begin
      wa       = {base[63:2], 2'b00} + 64'(i) * 64'd4;
      entry_hi = (i == 0) && base[1];
      if (!RVC_EN) begin
        exp_q.push_back('{seg_words[i], word_addr(base, i), 1'b0});
      end else begin
        if (!entry_hi) begin
          par.push_back(seg_words[i][15:0]); pa.push_back(wa); up.push_back(1'b0);
        end
        par.push_back(seg_words[i][31:16]); pa.push_back(wa + 64'd2); up.push_back(!entry_hi);
      end
    end
    j = 0;
    while (j < par.size()) begin
      p = par[j];
      if (p[1:0] != 2'b11) begin
        exp_q.push_back('{{16'h0000, p}, pa[j], up[j]});
        j = j + 1;
      end else if (j + 1 < par.size()) begin
        exp_q.push_back('{{par[j + 1], p}, pa[j], 1'b0});
        j = j + 2;
      end else begin
        break;
      end
    end
  endfunction

  task automatic run_segment(input logic [63:0] base, input bit use_reset, input int ready_pct);
    int          wi;
    int          cyc;
    bit          holding;
    bit          prev_stall;
    logic [31:0] last_instr;
    logic [63:0] last_addr;
    exp_t        e;

    build_expected(base);
    @(posedge clk_i); #1;
    instr_ready_i = 1'b1;
    if (use_reset) begin
      fetch_valid_i = 1'b0;
      fetch_addr_i  = '0;
      rst_ni        = 1'b0;
      #1;
      check("rst_valid", 64'(instr_valid_o), 64'd0);
      check("rst_ready", 64'(fetch_ready_o), 64'd1);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
    end else begin
      flush_i       = 1'b1;
      fetch_valid_i = RVC_EN;
      fetch_data_i  = $urandom;
      fetch_addr_i  = {$urandom, $urandom} & ~64'd3;
      @(negedge clk_i);
      if (RVC_EN) begin
        check("flush_valid", 64'(instr_valid_o), 64'd0);
        check("flush_ready", 64'(fetch_ready_o), 64'd1);
      end
      @(posedge clk_i); #1;
      flush_i       = 1'b0;
      fetch_valid_i = 1'b0;
    end

    wi = 0; cyc = 0; holding = 1'b0; prev_stall = 1'b0;
    last_instr = '0; last_addr = '0;
    while ((wi < seg_words.size() || exp_q.size() > 0) && cyc < BUDGET) begin
      if (!holding) begin
        if (wi < seg_words.size() && $urandom_range(0, 3) != 0) begin
          fetch_valid_i = 1'b1;
          fetch_data_i  = seg_words[wi];
          fetch_addr_i  = word_addr(base, wi);
          holding       = 1'b1;
        end else begin
          fetch_valid_i = 1'b0;
          fetch_data_i  = $urandom;
        end
      end
      instr_ready_i = ($urandom_range(0, 99) < ready_pct);
      @(negedge clk_i);
      if (instr_valid_o) begin
        if (prev_stall) begin
          check("stable_instr", 64'(instr_o), 64'(last_instr));
          check("stable_addr", instr_addr_o, last_addr);
        end
        if (exp_q.size() == 0) begin
          check("extra_instr", 64'(instr_valid_o), 64'd0);
        end else begin
          e = exp_q[0];
          if (e.buffered) check("fetch_hold", 64'(fetch_ready_o), 64'd0);
          else            check("fetch_ready", 64'(fetch_ready_o), 64'(instr_ready_i));
          if (instr_ready_i) begin
            check("instr", 64'(instr_o), 64'(e.instr));
            check("addr", instr_addr_o, e.addr);
            check("is_c", 64'(is_compressed_o),
                  64'(RVC_EN && (e.instr[1:0] != 2'b11)));
            void'(exp_q.pop_front());
          end
        end
        prev_stall = !instr_ready_i;
        last_instr = instr_o;
        last_addr  = instr_addr_o;
      end else begin
        if (prev_stall) check("valid_drop", 64'(instr_valid_o), 64'd1);
        prev_stall = 1'b0;
      end
      if (fetch_valid_i && fetch_ready_o) begin
        wi      = wi + 1;
        holding = 1'b0;
      end
      @(posedge clk_i); #1;
      cyc = cyc + 1;
    end
    fetch_valid_i = 1'b0;
    check("drained", 64'(exp_q.size()), 64'd0);
    check("consumed", 64'(wi), 64'(seg_words.size()));
  endtask

  initial begin
    logic [63:0] base;
    int          n;
    rst_ni        = 1'b0;
    flush_i       = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_data_i  = '0;
    fetch_addr_i  = '0;
    instr_ready_i = 1'b1;
    #1;
    check("por_valid", 64'(instr_valid_o), 64'd0);
    check("por_ready", 64'(fetch_ready_o), 64'd1);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    seg_words = '{32'h0000_0013};               run_segment(64'h1000, 1'b0, 100);
    seg_words = '{32'h4505_4501};               run_segment(64'h1000, 1'b0, 100);
    seg_words = '{32'h0013_4501, 32'h4501_0000}; run_segment(64'h1000, 1'b0, 100);
    seg_words = '{32'h4505_1234};               run_segment(64'h1002, 1'b0, 100);
    // Leave a half instruction buffered, then redirect by flush and by reset.
    seg_words = '{32'h0013_4501};               run_segment(64'h1000, 1'b0, 100);
    seg_words = '{32'h0000_0013};               run_segment(64'h2000, 1'b0, 100);
    seg_words = '{32'h0013_4501};               run_segment(64'h1000, 1'b0, 100);
    seg_words = '{32'h0000_0013};               run_segment(64'h2000, 1'b1, 100);
    seg_words = '{32'h4505_4501, 32'h4509_4507}; run_segment(64'h3000, 1'b0, 15);
    seg_words = '{32'h0013_4501, 32'h4505_0000, 32'h0000_0093};
    run_segment(64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 70);

    for (int s = 0; s < 30; s++) begin
      seg_words.delete();
      n = $urandom_range(4, 12);
      for (int i = 0; i < n; i++) seg_words.push_back({rand_half(), rand_half()});
      base = {$urandom, $urandom} & ~64'd1;
      run_segment(base, ($urandom_range(0, 7) == 0), $urandom_range(40, 100));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_align_seq.md
INSTR_ALIGN_SEQ -- requirements
Module: instr_align_seq

Interface
REQ-001 SHALL have port clk_i, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port flush_i, input, 1, discard all buffered state (branch/exception redirect).
REQ-004 SHALL have port fetch_valid_i, input, 1, fetch word available.
REQ-005 SHALL have port fetch_ready_o, output, 1, fetch word consumed this cycle when high with fetch_valid_i.
REQ-006 SHALL have port fetch_data_i, input, 32, word-aligned fetch data, little-endian halves.
REQ-007 SHALL have port fetch_addr_i, input, 64, fetch address; bit 1 set means entry at upper half (first word after redirect only).
REQ-008 SHALL have port instr_valid_o, output, 1, instruction presented to the compressed decoder.
REQ-009 SHALL have port instr_ready_i, input, 1, downstream accepts instruction.
REQ-010 SHALL have port instr_o, output, 32, raw instruction; compressed in bits [15:0], bits [31:16] zero.
REQ-011 SHALL have port instr_addr_o, output, 64, address of first parcel of instr_o.
REQ-012 SHALL have port is_compressed_o, output, 1, instr_o[1:0] != 2'b11.

Function
REQ-013 SHALL implement states ALIGNED, UPPER_C (buffered upper-half compressed instr), STRADDLE (buffered lower 16 bits of 32-bit instr).
REQ-014 ALIGNED, addr[1]=0, word[1:0]=11: emit full word at fetch_addr_i; fetch_ready_o=instr_ready_i; stay ALIGNED.
REQ-015 ALIGNED, addr[1]=0, word[1:0]!=11: emit word[15:0]; on handshake store word[31:16] and addr+2, consume word, go UPPER_C if word[17:16]!=11 else STRADDLE.
REQ-016 ALIGNED, addr[1]=1: ignore lower half; if word[17:16]!=11 emit upper compressed at addr, else emit nothing, fetch_ready_o=1, store upper half, go STRADDLE.
REQ-017 UPPER_C: emit stored parcel with stored address, fetch_ready_o=0; on instr handshake go ALIGNED.
REQ-018 STRADDLE: instr_valid_o=fetch_valid_i; emit {word[15:0], stored}; on handshake consume word, store word[31:16], go UPPER_C or STRADDLE per word[17:16].
REQ-019 Output paths from fetch inputs SHALL be combinational (zero latency); buffered parcel emission SHALL cost exactly one cycle.
REQ-020 instr_valid_o SHALL never depend on instr_ready_i; presented instr_o/addr SHALL stay stable while valid and not ready.
REQ-021 flush_i SHALL force instr_valid_o=0, fetch_ready_o=1 that cycle and state ALIGNED next cycle, overriding any simultaneous handshake.
REQ-022 Address arithmetic SHALL be 64-bit modulo 2^64; addr+2 wraps at 0xFFFF_FFFF_FFFF_FFFE.

Reset
REQ-023 On rst_ni low: state ALIGNED, stored parcel 0, stored address 0, instr_valid_o=0; fetch_ready_o follows ALIGNED rules.
REQ-024 Reset mid-STRADDLE/UPPER_C SHALL drop the buffered parcel with no output.

Configuration
REQ-025 Macro INSTR_ALIGN_SEQ_RVC_EN defined: full behaviour REQ-013..REQ-022.
REQ-026 Macro undefined: state fixed at ALIGNED, each fetch word passed through unchanged, is_compressed_o=0, fetch_ready_o=instr_ready_i, fetch_addr_i[1] ignored.

Structure
REQ-027 State enum (align_state_e) and constant PARCEL_W=16 SHALL live in ariane_pkg.
REQ-028 SHALL be a single module with no sub-modules; instr_o feeds compressed_decoder externally.

Verification
REQ-029 Word 0x0000_0013 at 0x1000 -> one instr 0x0000_0013, addr 0x1000, is_compressed 0.
REQ-030 Word 0x4505_4501 at 0x1000 -> cycle n instr 0x4501@0x1000, n+1 instr 0x4505@0x1002, fetch_ready_o=0 at n+1.
REQ-031 Words 0x0013_4501 then 0x4501_0000 at 0x1000/0x1004 -> 0x4501@0x1000, 0x0000_0013@0x1002, then 0x4501@0x1006.
REQ-032 Entry at 0x1002 with word 0x4505_xxxx -> only 0x4505@0x1002 emitted.
REQ-033 Flush asserted in STRADDLE -> no output that cycle; next word 0x0000_0013@0x2000 emitted as full instr.
REQ-034 instr_ready_i held low 5 cycles in UPPER_C -> instr_o, addr stable, no fetch consumed.
